// File: rtl/serial_pkg.sv
// Shared types for the serial receive path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_pkg;

    // Receiver control state: Idle holds the datapath cleared, Receive samples bits.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } t_deserial_state;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser bringing one asynchronous bit into the in_clk domain.
// Latency: STAGES in_clk cycles from in_d to out_q.
// Backpressure: none; the input is sampled every cycle.
//
// Ports:
//   in_clk  - destination clock
//   in_rst  - synchronous active-low reset, loads every stage with INIT
//   in_d    - asynchronous input bit
//   out_q   - synchronised output bit
module sync_ff #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_d,
    output logic out_q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            chain <= {STAGES{INIT}};
        end else begin
            chain[0] <= in_d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign out_q = chain[STAGES-1];

endmodule

// File: rtl/deserial.sv
// Serial-to-parallel receiver: samples in_serial on the active edge of an async serial clock.
// Latency: SYNC_STAGES + 1 in_clk cycles from the final serial clock edge to out_valid.
// Backpressure: out_valid/in_ack handshake; a word completing while the previous one is unacked is dropped and flags out_overrun.
//
// Ports:
//   in_clk, in_rst     - main clock, synchronous active-low reset
//   in_enable          - receive enable; dropping it aborts a partial word and clears out_overrun
//   in_serial_clk      - async serial clock, idles at SERIAL_CLK_INACTIVE
//   in_serial          - async serial data
//   in_ack             - consumer accepts out_parallel when out_valid=1
//   out_parallel       - last completed word
//   out_valid          - word available until acknowledged
//   out_busy           - a partial word is held
//   out_overrun        - sticky: a completed word was dropped
module deserial
    import serial_pkg::*;
#(
    parameter int BITS                = 8,
    parameter int LOWBIT_FIRST        = 1,
    parameter int SERIAL_CLK_INACTIVE = 1,
    parameter int SYNC_STAGES         = 2,
    parameter int TIMEOUT_CYCLES      = 50_000
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_enable,
    input  logic            in_serial_clk,
    input  logic            in_serial,
    input  logic            in_ack,
    output logic [BITS-1:0] out_parallel,
    output logic            out_valid,
    output logic            out_busy,
    output logic            out_overrun
);

    localparam int   CNT_W    = $clog2(BITS) + 1;
    localparam int   IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic CLK_IDLE = (SERIAL_CLK_INACTIVE != 0);

    localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(BITS - 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    t_deserial_state   state_q;
    t_deserial_state   state_d;

    logic              clk_sync;
    logic              dat_sync;
    logic              clk_prev;
    logic              sample_edge;

    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_pos;
    logic [IDLE_W-1:0] idle_cnt;
    logic [BITS-1:0]   shreg;
    logic [BITS-1:0]   shreg_nxt;

    logic              busy;
    logic              take_bit;
    logic              discard;
    logic              timeout_hit;
    logic              word_done;
    logic              accept;

    sync_ff #(.STAGES(SYNC_STAGES), .INIT(CLK_IDLE)) u_sync_clk (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_d   (in_serial_clk),
        .out_q  (clk_sync)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_dat (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .in_d   (in_serial),
        .out_q  (dat_sync)
    );

    // Only the idle-to-active transition samples; the return to idle is ignored.
    assign sample_edge = (clk_prev == CLK_IDLE) && (clk_sync != CLK_IDLE);

    assign busy        = (bit_cnt != '0);
    assign timeout_hit = busy && (idle_cnt == TIMEOUT_LAST);
    assign word_done   = take_bit && (bit_cnt == LAST_BIT);
    assign accept      = out_valid && in_ack;
    assign bit_pos     = (LOWBIT_FIRST != 0) ? bit_cnt : (LAST_BIT - bit_cnt);

    // Shift register image with the current data bit dropped into its slot.
    always_comb begin
        shreg_nxt = shreg;
        for (int i = 0; i < BITS; i++) begin
            if (bit_pos == CNT_W'(i)) begin
                shreg_nxt[i] = dat_sync;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        take_bit = 1'b0;
        discard  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_enable) begin
                    state_d = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (!in_enable) begin
                    state_d = ST_IDLE;
                    discard = 1'b1;
                end else if (sample_edge) begin
                    take_bit = 1'b1;
                end else if (timeout_hit) begin
                    discard = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_q      <= ST_IDLE;
            clk_prev     <= CLK_IDLE;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            shreg        <= '0;
            out_parallel <= '0;
            out_valid    <= 1'b0;
            out_overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_prev <= clk_sync;

            if (state_q == ST_IDLE || discard) begin
                bit_cnt  <= '0;
                shreg    <= '0;
                idle_cnt <= '0;
            end else if (take_bit) begin
                idle_cnt <= '0;
                if (word_done) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    shreg   <= shreg_nxt;
                end
            end else if (busy) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            // A completing word may replace the held one only if the slot is free or freed this cycle.
            if (word_done && (!out_valid || accept)) begin
                out_parallel <= shreg_nxt;
                out_valid    <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            if (!in_enable) begin
                out_overrun <= 1'b0;
            end else if (word_done && out_valid && !in_ack) begin
                out_overrun <= 1'b1;
            end
        end
    end

    assign out_busy = busy;

endmodule

// File: doc/deserial.md
DESERIAL -- requirements
Module: deserial

Interface
REQ-001 The block SHALL have parameter BITS, default 8, meaning word length.
REQ-002 The block SHALL have parameter LOWBIT_FIRST, default 1, meaning 1 = first received bit goes to bit 0, 0 = first bit goes to bit BITS-1.
REQ-003 The block SHALL have parameter SERIAL_CLK_INACTIVE, default 1, meaning idle level of in_serial_clk.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth for in_serial_clk and in_serial.
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000, meaning the number of in_clk cycles without a sampling edge that aborts a partial word.
REQ-006 The block SHALL have port in_clk, input, 1 bit, the main clock.
REQ-007 The block SHALL have port in_rst, input, 1 bit, reset; reset is synchronous to in_clk and active-low.
REQ-008 The block SHALL have port in_enable, input, 1 bit, receive enable.
REQ-009 The block SHALL have port in_serial_clk, input, 1 bit, the asynchronous serial clock.
REQ-010 The block SHALL have port in_serial, input, 1 bit, the asynchronous serial data.
REQ-011 The block SHALL have port in_ack, input, 1 bit, consumer acknowledge of out_parallel.
REQ-012 The block SHALL have port out_parallel, output, BITS bits, the received word.
REQ-013 The block SHALL have port out_valid, output, 1 bit, word-available level.
REQ-014 The block SHALL have port out_busy, output, 1 bit, high while a partial word is held.
REQ-015 The block SHALL have port out_overrun, output, 1 bit, sticky word-dropped flag.

Function
REQ-016 in_serial_clk and in_serial SHALL pass through SYNC_STAGES in_clk flip-flops before any use.
REQ-017 A sampling edge SHALL be one in_clk cycle in which the synchronised clock changes from SERIAL_CLK_INACTIVE to its complement; the opposite transition SHALL be ignored.
REQ-018 States SHALL be Idle and Receive; Idle->Receive when in_enable=1; Receive->Idle when in_enable=0; transitions take effect on the next in_clk edge.
REQ-019 In Idle, sampling edges SHALL be ignored, the bit counter and shift register SHALL be zero, and out_busy=0.
REQ-020 In Receive, each sampling edge SHALL store the synchronised data bit into the shift register at position LOWBIT_FIRST ? k : BITS-1-k (k = bit counter) and increment the counter.
REQ-021 On the BITS-th sampling edge, the counter SHALL return to 0, and in the next cycle out_parallel SHALL hold the full word and out_valid SHALL be 1.
REQ-022 The counter width SHALL be $clog2(BITS)+1 bits; the counter SHALL never exceed BITS-1.
REQ-023 out_valid SHALL remain 1 until a cycle with in_ack=1 and out_valid=1, and SHALL be 0 the cycle after; in_ack while out_valid=0 SHALL be ignored.
REQ-024 A word that completes in the same cycle as an accepted in_ack SHALL load out_parallel, keep out_valid=1, and SHALL NOT set out_overrun.
REQ-025 A word that completes while out_valid=1 without in_ack SHALL be dropped, out_parallel SHALL be unchanged, and out_overrun SHALL be set to 1.
REQ-026 out_overrun SHALL clear only on reset or in a cycle with in_enable=0.
REQ-027 in_enable falling mid-word SHALL discard the partial word, zero the counter, and leave out_valid/out_parallel untouched.
REQ-028 The idle counter SHALL run in Receive while out_busy=1 and reset on every sampling edge; when it reaches TIMEOUT_CYCLES, the partial word SHALL be discarded and the counter zeroed, with the state remaining Receive.
REQ-029 out_busy SHALL equal (bit counter != 0).

Reset
REQ-030 While in_rst=0 at an in_clk edge: state=Idle, counters=0, shift register=0, out_parallel=0, out_valid=0, out_busy=0, out_overrun=0, and synchroniser flops=SERIAL_CLK_INACTIVE (clock) and 0 (data).
REQ-031 Reset mid-word SHALL discard all partial data; no word SHALL be produced from bits sampled before the reset.

Structure
REQ-032 The state enum t_deserial_state (Idle, Receive) SHALL live in the shared package serial_pkg.
REQ-033 The synchroniser chain SHALL be a sub-module sync_ff (parameters STAGES, INIT), instantiated once per async input.

Verification
REQ-034 BITS=8, LOWBIT_FIRST=1, in_enable=1: send bits 1,0,1,0,0,1,0,1 -> out_parallel=8'hA5, out_valid=1 one cycle after the 8th detected edge.
REQ-035 LOWBIT_FIRST=0: send 0,0,1,1,1,1,0,0 -> out_parallel=8'h3C.
REQ-036 Send 8'h11 and hold in_ack=0, then send 8'h22 -> out_parallel stays 8'h11 and out_overrun=1; then in_enable=0 for 1 cycle -> out_overrun=0.
REQ-037 Send 3 bits, drop in_enable for 1 cycle, re-enable, and send 8'h5A -> out_parallel=8'h5A with no stray bits.
REQ-038 Use TIMEOUT_CYCLES=20: send 4 bits, then stall 20 cycles -> out_busy=0; the next 8 bits of 8'hC3 yield 8'hC3.
REQ-039 Pull in_rst low after 5 bits of a word, then release, then send 8'hF0 -> exactly one word is produced, with out_parallel=8'hF0.
